turn_cursor_fsm: RTL

Parametrised turn-and-cursor controller for the board-game front end. It sequences board setup, cursor movement with auto-repeat and wrap-around, disk placement for NUM_PLAYERS rotating players, and end-of-game detection. It drives the pixel drawing engine through a req/done handshake and queries the rules engine for placement legality. It sits between the keyboard decoder and the VGA drawing datapath.

---
 rtl/turn_cursor_fsm_if.sv | 11 +
 rtl/turn_cursor_fsm.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/turn_cursor_fsm_if.sv
// Drawing-engine handshake between the turn/cursor controller and the
// pixel drawing datapath. The controller holds draw_req and draw_kind
// steady until it samples draw_done.
interface turn_cursor_fsm_if;
    logic       draw_req;
    logic [1:0] draw_kind;
    logic       draw_done;

    modport master (output draw_req, output draw_kind, input draw_done);
    modport slave  (input draw_req, input draw_kind, output draw_done);
endinterface

// File: rtl/turn_cursor_fsm.sv
// Turn-and-cursor controller for the board-game front end: sets up the
// board, moves a wrapping cursor with auto-repeat, places disks for a
// rotating set of players and stops when the rules engine reports a win.
module turn_cursor_fsm #(
    parameter int BOARD_W       = 8,
    parameter int BOARD_H       = 8,
    parameter int NUM_PLAYERS   = 2,
    parameter int REPEAT_CYCLES = 833333,
    localparam int XW = (BOARD_W > 1) ? $clog2(BOARD_W) : 1,
    localparam int YW = (BOARD_H > 1) ? $clog2(BOARD_H) : 1,
    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                    clk,
    input  logic                    restart,
    input  logic                    go,
    input  logic                    move_up,
    input  logic                    move_down,
    input  logic                    move_left,
    input  logic                    move_right,
    input  logic                    place,
    input  logic                    place_legal,
    input  logic                    win,
    output logic [XW-1:0]           cur_x,
    output logic [YW-1:0]           cur_y,
    output logic [PW-1:0]           turn,
    output logic                    illegal,
    output logic [3:0]              state,
    turn_cursor_fsm_if.master       draw_if
);

    localparam int RW = $clog2(REPEAT_CYCLES);

    localparam logic [XW-1:0] X_MAX  = XW'(BOARD_W - 1);
    localparam logic [YW-1:0] Y_MAX  = YW'(BOARD_H - 1);
    localparam logic [PW-1:0] P_MAX  = PW'(NUM_PLAYERS - 1);
    localparam logic [RW-1:0] R_LOAD = RW'(REPEAT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_BOARD  = 4'd1,
        S_SELECT = 4'd2,
        S_ERASE  = 4'd3,
        S_MOVE   = 4'd4,
        S_PLACE  = 4'd5,
        S_CHECK  = 4'd6,
        S_END    = 4'd7
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    state_t          state_q, state_d;
    dir_t            dir_q, dir_d;
    logic [XW-1:0]   cur_x_q, cur_x_d;
    logic [YW-1:0]   cur_y_q, cur_y_d;
    logic [PW-1:0]   turn_q, turn_d;
    logic            illegal_q, illegal_d;
    logic [RW-1:0]   rpt_q, rpt_d;
    logic            rpt_load;
    logic            go_q, place_q;
    logic            draw_req_w;
    logic [1:0]      draw_kind_w;

    wire go_rise    = go & ~go_q;
    wire place_rise = place & ~place_q;
    wire any_move   = move_up | move_down | move_left | move_right;

    // State, cursor, turn, repeat counter and input edge history.
    // NOTE: every register here uses <= so all of them update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (restart) begin
            state_q   <= S_IDLE;
            dir_q     <= DIR_UP;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            turn_q    <= '0;
            illegal_q <= 1'b0;
            rpt_q     <= '0;
            go_q      <= 1'b0;
            place_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            turn_q    <= turn_d;
            illegal_q <= illegal_d;
            rpt_q     <= rpt_d;
            go_q      <= go;
            place_q   <= place;
        end
    end

    // Next-state, cursor stepping, turn rotation and the illegal-place pulse.
    // NOTE: every variable gets its hold value first so no branch can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        turn_d    = turn_q;
        illegal_d = 1'b0;
        rpt_load  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go_rise) begin
                    cur_x_d = '0;
                    cur_y_d = '0;
                    turn_d  = '0;
                    state_d = S_BOARD;
                end
            end
            S_BOARD: begin
                if (draw_if.draw_done) state_d = S_MOVE;
            end
            S_SELECT: begin
                // A place edge wins over any held direction key.
                if (place_rise) begin
                    if (place_legal) state_d   = S_PLACE;
                    else             illegal_d = 1'b1;
                end else if (any_move && (rpt_q == '0)) begin
                    rpt_load = 1'b1;
                    state_d  = S_ERASE;
                    if (move_up)        dir_d = DIR_UP;
                    else if (move_down) dir_d = DIR_DOWN;
                    else if (move_left) dir_d = DIR_LEFT;
                    else                dir_d = DIR_RIGHT;
                end
            end
            S_ERASE: begin
                // The old cell is erased first; the cursor moves as the erase completes.
                if (draw_if.draw_done) begin
                    state_d = S_MOVE;
                    case (dir_q)
                        DIR_UP:    cur_y_d = (cur_y_q == '0)    ? Y_MAX : cur_y_q - YW'(1);
                        DIR_DOWN:  cur_y_d = (cur_y_q == Y_MAX) ? '0    : cur_y_q + YW'(1);
                        DIR_LEFT:  cur_x_d = (cur_x_q == '0)    ? X_MAX : cur_x_q - XW'(1);
                        default:   cur_x_d = (cur_x_q == X_MAX) ? '0    : cur_x_q + XW'(1);
                    endcase
                end
            end
            S_MOVE: begin
                if (draw_if.draw_done) state_d = S_SELECT;
            end
            S_PLACE: begin
                if (draw_if.draw_done) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (win) begin
                    state_d = S_END;
                end else begin
                    turn_d  = (turn_q == P_MAX) ? '0 : turn_q + PW'(1);
                    state_d = S_MOVE;
                end
            end
            S_END: begin
                if (go_rise) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Auto-repeat counter: cleared while no key is held, reloaded on each step.
    always_comb begin
        rpt_d = rpt_q;
        if (!any_move)          rpt_d = '0;
        else if (rpt_load)      rpt_d = R_LOAD;
        else if (rpt_q != '0)   rpt_d = rpt_q - RW'(1);
    end

    // Drawing request decoded purely from the registered state.
    always_comb begin
        draw_req_w  = 1'b0;
        draw_kind_w = 2'd0;
        case (state_q)
            S_BOARD: begin draw_req_w = 1'b1; draw_kind_w = 2'd3; end
            S_ERASE: begin draw_req_w = 1'b1; draw_kind_w = 2'd0; end
            S_MOVE:  begin draw_req_w = 1'b1; draw_kind_w = 2'd1; end
            S_PLACE: begin draw_req_w = 1'b1; draw_kind_w = 2'd2; end
            default: ;
        endcase
    end

    assign draw_if.draw_req  = draw_req_w;
    assign draw_if.draw_kind = draw_kind_w;
    assign cur_x             = cur_x_q;
    assign cur_y             = cur_y_q;
    assign turn              = turn_q;
    assign illegal           = illegal_q;
    assign state             = state_q;

endmodule
